// File: rtl/adc_channel_filter.sv
// Snapshot, tear-check and EMA-filter the 8 LTC2308 channel lanes.
// Publishes filtered values and hysteretic threshold flags.
module adc_channel_filter #(
  parameter int          SAMPLE_DIV = 2500,
  parameter int          SHIFT      = 3,
  parameter int          MAX_RETRY  = 4,
  parameter logic [11:0] THRESH_HI  = 12'd3000,
  parameter logic [11:0] THRESH_LO  = 12'd2500
) (
  input  logic         sys_clk,
  input  logic         reset_n,
  input  logic         enable,
  input  logic [255:0] adc_channels,
  output logic [95:0]  filt_channels,
  output logic         filt_valid,
  output logic [7:0]   above,
  output logic [7:0]   drop_count,
  output logic         busy
);

  localparam int AW = 12 + SHIFT;
  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SAMPLE_DIV - 1);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_VERIFY,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] cnt_q;
  logic          tick;
  logic [11:0]   live   [8];
  logic [11:0]   snap_q [8];
  logic [AW-1:0] acc_q  [8];
  logic [11:0]   filt_q [8];
  logic          primed_q;
  logic [3:0]    retry_q;
  logic [2:0]    ch_q;
  logic          torn;
  logic          snap_en;
  logic          upd_en;
  logic          retry_clr;
  logic          retry_inc;
  logic          torn_drop;
  logic          overrun;
  logic [1:0]    n_drop;
  logic [8:0]    drop_sum;
  logic [AW-1:0] acc_cur;
  logic [AW-1:0] acc_new;
  logic [11:0]   filt_new;
  logic          above_new;
  logic          unused_hi;

  assign tick = enable && (cnt_q == CNT_MAX);

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (!enable || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Only the 12-bit sample field of each lane matters.
  always_comb begin
    unused_hi = 1'b0;
    for (int i = 0; i < 8; i++) begin
      live[i]   = adc_channels[32*i +: 12];
      unused_hi = unused_hi ^ (^adc_channels[32*i+12 +: 20]);
    end
  end

  always_comb begin
    torn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (live[i] != snap_q[i]) begin
        torn = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    snap_en   = 1'b0;
    upd_en    = 1'b0;
    retry_clr = 1'b0;
    retry_inc = 1'b0;
    torn_drop = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        snap_en = 1'b1;
        state_d = S_VERIFY;
      end
      S_VERIFY: begin
        if (!torn) begin
          retry_clr = 1'b1;
          state_d   = S_UPDATE;
        end else if (4'(retry_q + 4'd1) == RETRY_MAX) begin
          torn_drop = 1'b1;
          retry_clr = 1'b1;
          state_d   = S_IDLE;
        end else begin
          retry_inc = 1'b1;
          state_d   = S_CAPTURE;
        end
      end
      S_UPDATE: begin
        upd_en = 1'b1;
        if (ch_q == 3'd7) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign overrun  = tick && (state_q != S_IDLE);
  assign n_drop   = {1'b0, torn_drop} + {1'b0, overrun};
  assign drop_sum = {1'b0, drop_count} + {7'b0, n_drop};

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      retry_q    <= '0;
      drop_count <= '0;
      ch_q       <= '0;
      primed_q   <= 1'b0;
    end else begin
      if (retry_clr) begin
        retry_q <= '0;
      end else if (retry_inc) begin
        retry_q <= retry_q + 4'd1;
      end
      drop_count <= drop_sum[8] ? 8'hff : drop_sum[7:0];
      ch_q       <= upd_en ? 3'(ch_q + 3'd1) : 3'd0;
      if (state_q == S_DONE) begin
        primed_q <= 1'b1;
      end
    end
  end

  // First frame after reset loads the raw sample instead of blending.
  always_comb begin
    acc_cur = acc_q[ch_q];
    if (primed_q) begin
      acc_new = acc_cur - (acc_cur >> SHIFT) + AW'(snap_q[ch_q]);
    end else begin
      acc_new = AW'(snap_q[ch_q]) << SHIFT;
    end
    filt_new = acc_new[SHIFT +: 12];
    if (filt_new >= THRESH_HI) begin
      above_new = 1'b1;
    end else if (filt_new < THRESH_LO) begin
      above_new = 1'b0;
    end else begin
      above_new = above[ch_q];
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        snap_q[i] <= '0;
        acc_q[i]  <= '0;
        filt_q[i] <= '0;
      end
      above <= '0;
    end else begin
      if (snap_en) begin
        for (int i = 0; i < 8; i++) begin
          snap_q[i] <= live[i];
        end
      end
      if (upd_en) begin
        acc_q[ch_q]  <= acc_new;
        filt_q[ch_q] <= filt_new;
        above[ch_q]  <= above_new;
      end
    end
  end

  always_comb begin
    filt_channels = '0;
    for (int i = 0; i < 8; i++) begin
      filt_channels[12*i +: 12] = filt_q[i];
    end
  end

  assign filt_valid = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_adc_channel_filter.sv
// Directed bench for adc_channel_filter: priming, EMA step,
// hysteresis, torn snapshots, mid-frame reset, enable gating.
module tb_adc_channel_filter;

  logic         sys_clk = 1'b0;
  logic         reset_n;
  logic         enable;
  logic [255:0] adc;
  logic [95:0]  filt;
  logic         filt_valid;
  logic [7:0]   above;
  logic [7:0]   drop_count;
  logic         busy;

  int total = 0;
  int bad   = 0;

  always #5 sys_clk = ~sys_clk;

  adc_channel_filter #(
    .SAMPLE_DIV(32),
    .SHIFT(3),
    .MAX_RETRY(4),
    .THRESH_HI(12'd3000),
    .THRESH_LO(12'd2500)
  ) dut (
    .sys_clk(sys_clk),
    .reset_n(reset_n),
    .enable(enable),
    .adc_channels(adc),
    .filt_channels(filt),
    .filt_valid(filt_valid),
    .above(above),
    .drop_count(drop_count),
    .busy(busy)
  );

  function automatic logic [11:0] lane(input int ch);
    return filt[12*ch +: 12];
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_lane(input int ch, input logic [11:0] v);
    adc[32*ch +: 32] = {20'hface0 ^ 20'(ch), v};
  endtask

  task automatic set_all(input logic [11:0] v);
    for (int i = 0; i < 8; i++) set_lane(i, v);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable  = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wait_rise(output int n, output bit to);
    int k;
    to = 1'b0;
    k  = 0;
    while (busy === 1'b1 && k < 100) begin
      @(negedge sys_clk);
      k++;
    end
    n = 0;
    forever begin
      @(negedge sys_clk);
      if (busy === 1'b1) break;
      n++;
      if (n > 200) begin
        to = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(output int n, output bit to);
    to = 1'b0;
    n  = 0;
    forever begin
      @(negedge sys_clk);
      n++;
      if (filt_valid === 1'b1) break;
      if (n > 60) begin
        to = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    bit to;
    reset_n = 1'b0;
    enable  = 1'b1;
    set_all(12'd2048);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    total++;
    if (filt !== 96'd0) begin
      bad++; $display("FAIL rst_filt got=%h exp=0", filt);
    end
    total++;
    if (filt_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_flags got=%b%b exp=00", filt_valid, busy);
    end
    total++;
    if (above !== 8'd0 || drop_count !== 8'd0) begin
      bad++; $display("FAIL rst_cnt got=%h/%h exp=0/0", above, drop_count);
    end
    step();
    reset_n = 1'b1;
    wait_rise(n, to);
    total++;
    if (to || n !== 32) begin
      bad++; $display("FAIL first_tick got=%0d exp=32", n);
    end
    wait_valid(n, to);
    total++;
    if (to || n !== 10) begin
      bad++; $display("FAIL latency got=%0d exp=10", n);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (lane(i) !== 12'd2048) begin
        bad++; $display("FAIL prime_lane%0d got=%0d exp=2048", i, lane(i));
      end
    end
    @(negedge sys_clk);
    total++;
    if (filt_valid !== 1'b0) begin
      bad++; $display("FAIL valid_pulse got=%b exp=0", filt_valid);
    end
    set_all(12'd1000);
    wait_rise(n, to);
    wait_valid(n, to);
    total++;
    if (to || lane(6) !== 12'd1917) begin
      bad++; $display("FAIL primed_ema got=%0d exp=1917", lane(6));
    end
  endtask

  task automatic test_step();
    int n;
    bit to;
    int exp_t [10] = '{511, 959, 1351, 1694, 1995,
                       2257, 2487, 2688, 2864, 3018};
    set_all(12'd2048);
    set_lane(0, 12'd0);
    do_reset();
    wait_rise(n, to);
    wait_valid(n, to);
    total++;
    if (to || lane(0) !== 12'd0) begin
      bad++; $display("FAIL step_prime got=%0d exp=0", lane(0));
    end
    step();
    set_lane(0, 12'd4095);
    for (int i = 0; i < 10; i++) begin
      wait_rise(n, to);
      wait_valid(n, to);
      total++;
      if (to || lane(0) !== 12'(exp_t[i])) begin
        bad++; $display("FAIL step_f%0d got=%0d exp=%0d", i, lane(0), exp_t[i]);
      end
      total++;
      if (above[0] !== (i == 9)) begin
        bad++; $display("FAIL step_above_f%0d got=%b exp=%b", i, above[0], i == 9);
      end
    end
    total++;
    if (lane(4) !== 12'd2048) begin
      bad++; $display("FAIL step_other got=%0d exp=2048", lane(4));
    end
  endtask

  task automatic test_hysteresis();
    int n;
    bit to;
    int mid_t [3]  = '{3050, 3006, 2968};
    int low_t [14] = '{2897, 2834, 2780, 2733, 2691, 2655, 2623,
                       2595, 2571, 2549, 2531, 2514, 2500, 2487};
    set_all(12'd100);
    set_lane(1, 12'd3100);
    do_reset();
    wait_rise(n, to);
    wait_valid(n, to);
    total++;
    if (to || lane(1) !== 12'd3100 || above !== 8'h02) begin
      bad++; $display("FAIL hyst_prime got=%0d/%h exp=3100/02", lane(1), above);
    end
    step();
    set_lane(1, 12'd2700);
    for (int i = 0; i < 3; i++) begin
      wait_rise(n, to);
      wait_valid(n, to);
      total++;
      if (to || lane(1) !== 12'(mid_t[i]) || above[1] !== 1'b1) begin
        bad++; $display("FAIL hyst_mid%0d got=%0d/%b exp=%0d/1", i, lane(1), above[1], mid_t[i]);
      end
    end
    step();
    set_lane(1, 12'd2400);
    for (int i = 0; i < 14; i++) begin
      wait_rise(n, to);
      wait_valid(n, to);
      total++;
      if (to || lane(1) !== 12'(low_t[i]) || above[1] !== (i < 13)) begin
        bad++; $display("FAIL hyst_low%0d got=%0d/%b exp=%0d/%b", i, lane(1), above[1], low_t[i], i < 13);
      end
    end
  endtask

  task automatic test_torn_drop();
    int n;
    bit to;
    bit seen;
    set_all(12'd500);
    do_reset();
    wait_rise(n, to);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      set_lane(3, 12'(k * 37 + 1));
      @(negedge sys_clk);
      if (filt_valid === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL torn_valid got=%b exp=0", seen);
    end
    total++;
    if (drop_count !== 8'd1 || busy !== 1'b0) begin
      bad++; $display("FAIL torn_drop got=%0d/%b exp=1/0", drop_count, busy);
    end
    step();
    set_lane(3, 12'd500);
    wait_rise(n, to);
    wait_valid(n, to);
    total++;
    if (to || n !== 10 || lane(3) !== 12'd500 || drop_count !== 8'd1) begin
      bad++; $display("FAIL torn_recover got=%0d/%0d/%0d exp=10/500/1", n, lane(3), drop_count);
    end
  endtask

  task automatic test_torn_once();
    int n;
    bit to;
    set_all(12'd700);
    do_reset();
    wait_rise(n, to);
    step();
    set_lane(5, 12'd1234);
    wait_valid(n, to);
    total++;
    if (to || n !== 12) begin
      bad++; $display("FAIL once_latency got=%0d exp=12", n);
    end
    total++;
    if (lane(5) !== 12'd1234 || drop_count !== 8'd0) begin
      bad++; $display("FAIL once_val got=%0d/%0d exp=1234/0", lane(5), drop_count);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit to;
    set_all(12'd3500);
    do_reset();
    wait_rise(n, to);
    wait_valid(n, to);
    total++;
    if (to || lane(2) !== 12'd3500 || above !== 8'hff) begin
      bad++; $display("FAIL mid_prime got=%0d/%h exp=3500/ff", lane(2), above);
    end
    step();
    set_all(12'd2000);
    wait_rise(n, to);
    repeat (6) step();
    total++;
    if (busy !== 1'b1 || lane(0) === 12'd3500) begin
      bad++; $display("FAIL mid_inflight got=%b/%0d exp=1/not3500", busy, lane(0));
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (filt !== 96'd0 || above !== 8'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_clear got=%h/%h/%b exp=0/0/0", filt, above, busy);
    end
    repeat (2) @(posedge sys_clk);
    #1;
    reset_n = 1'b1;
    wait_rise(n, to);
    wait_valid(n, to);
    total++;
    if (to || lane(0) !== 12'd2000 || lane(7) !== 12'd2000 || above !== 8'd0) begin
      bad++; $display("FAIL mid_reprime got=%0d/%0d/%h exp=2000/2000/0", lane(0), lane(7), above);
    end
  endtask

  task automatic test_enable();
    int n;
    bit to;
    bit seen;
    set_all(12'd1500);
    do_reset();
    wait_rise(n, to);
    step();
    enable = 1'b0;
    wait_valid(n, to);
    total++;
    if (to || n !== 10 || lane(0) !== 12'd1500) begin
      bad++; $display("FAIL en_finish got=%0d/%0d exp=10/1500", n, lane(0));
    end
    seen = 1'b0;
    step();
    repeat (80) begin
      @(negedge sys_clk);
      if (busy === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL en_hold got=%b exp=0", seen);
    end
    step();
    enable = 1'b1;
    wait_rise(n, to);
    total++;
    if (to || n !== 32) begin
      bad++; $display("FAIL en_restart got=%0d exp=32", n);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    adc     = '0;
    test_reset();
    test_step();
    test_hysteresis();
    test_torn_drop();
    test_torn_once();
    test_reset_mid();
    test_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
